vga_timing_gen: RTL and testbench
=================================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL provide parameter CLK_DIV, default 6: clk cycles per pixel, legal range 1..64.
REQ-002 SHALL provide parameters H_VISIBLE 800, H_FRONT 40, H_SYNC 128, H_BACK 88: horizontal timing in pixels.
REQ-003 SHALL provide parameters V_VISIBLE 600, V_FRONT 1, V_SYNC 4, V_BACK 23: vertical timing in lines.
REQ-004 SHALL provide parameters H_POL 1 and V_POL 1: active sync level, 1 = positive.
REQ-005 SHALL provide parameter CW, default 4: bits per colour component.
REQ-006 SHALL provide parameters HW 11 and VW 10: widths of the horizontal and vertical counters.
REQ-007 Ports (name, direction, width, meaning):
  clk  in  1  single clock; all logic is on its rising edge.
  rst_n  in  1  asynchronous reset, active-low.
  en  in  1  run enable.
  pix_r, pix_g, pix_b  in  CW each  colour for the current (pix_x, pix_y).
  pix_x  out  HW  current column = hcount.
  pix_y  out  VW  current line = vcount.
  pix_req  out  1  one-clk strobe: the colour inputs are sampled this cycle.
  vga_hsync, vga_vsync  out  1 each  registered sync outputs.
  vga_r, vga_g, vga_b  out  CW each  registered colour outputs.
  line_start  out  1  one-clk pulse, aligned with the output pixel at hcount 0.
  frame_start  out  1  one-clk pulse, aligned with the output pixel (0,0).

Function
REQ-008 SHALL hold tick counter 0..CLK_DIV-1; strobe = en && tick==CLK_DIV-1; CLK_DIV=1 gives strobe = en on every clk.
REQ-009 SHALL define H_TOTAL as the sum of the four H parameters and V_TOTAL as the sum of the four V parameters, both computed at elaboration; the widths SHALL hold H_TOTAL-1 and V_TOTAL-1.
REQ-010 SHALL advance hcount on each strobe, wrapping from H_TOTAL-1 to 0.
REQ-011 SHALL advance vcount only on a strobe where hcount wraps, with vcount wrapping from V_TOTAL-1 to 0.
REQ-012 SHALL use line order: visible [0, H_VISIBLE), front porch, sync, back porch.
REQ-013 SHALL treat hsync as active for H_VISIBLE+H_FRONT <= hcount < H_VISIBLE+H_FRONT+H_SYNC; vsync SHALL use the same form with the V parameters.
REQ-014 SHALL define visible = hcount<H_VISIBLE && vcount<V_VISIBLE.
REQ-015 SHALL assert pix_req = strobe && visible, combinationally, using the pre-increment counters.
REQ-016 On every strobe, SHALL register the outputs from the pre-increment counters:
  - vga_hsync = H_POL when hsync is active, else ~H_POL; vga_vsync uses V_POL the same way.
  - vga_r/g/b = pix_r/g/b when visible, else 0.
  - line_start = (hcount==0).
  - frame_start = (hcount==0 && vcount==0).
REQ-017 Output latency SHALL be exactly 1 clk after the strobe; syncs and colour SHALL stay mutually aligned.
REQ-018 SHALL hold vga_* constant between strobes.
REQ-019 line_start and frame_start SHALL clear on the clk after they are set, so each is high for 1 clk only.
REQ-020 When en=0, on each clk SHALL set: tick, hcount and vcount to 0; colours to 0; syncs to their inactive level; pulses to 0; pix_req=0.
REQ-021 After en rises, the first strobe SHALL occur at the CLK_DIV-th clk, and frame_start SHALL follow it 1 clk later.
REQ-022 A hcount wrap at vcount=V_TOTAL-1 SHALL wrap both counters on the same strobe.
REQ-023 Arithmetic SHALL be unsigned, and no counter SHALL exceed its TOTAL-1.

Reset
REQ-024 While rst_n=0, SHALL asynchronously force: tick, hcount, vcount = 0; vga_r/g/b = 0; vga_hsync = ~H_POL; vga_vsync = ~V_POL; line_start, frame_start = 0.
REQ-025 On rst_n release, SHALL resume per REQ-021 if en=1.
REQ-026 Reset asserted mid-line SHALL abandon the line, with no partial sync pulse kept.

Verification (bench parameters: CLK_DIV=2, H 8/2/3/3, V 4/1/2/1, CW=4; H_TOTAL=16, V_TOTAL=8)
REQ-027 Reset release with en=1 and pix=constant F,0,A -> frame_start at clk 2; the frame period is exactly 256 clk; vga_r=F for 8 pixels per line on lines 0..3 and 0 otherwise.
REQ-028 Sync check -> vga_hsync is active for pixels 10..12, i.e. 6 clk per line; vga_vsync is active for lines 5..6, i.e. 64 clk.
REQ-029 Rerun with H_POL=0, V_POL=0 -> both sync outputs are inverted; reset drives them to 1.
REQ-030 Rerun with CLK_DIV=1 -> a strobe on every clk; frame period is 128 clk; output is 1 clk behind pix_req.
REQ-031 Drop en at hcount=5, vcount=2 -> next clk: outputs blank and syncs inactive; en high again -> frame_start 2 clk later.
REQ-032 Assert rst_n=0 mid-hsync -> vga_hsync goes inactive immediately without waiting for a clk edge; counters read 0.

Source files
------------

// File: rtl/vga_timing_gen.sv
// Purpose : VGA raster timing generator; pixel clock is a divided strobe of clk,
//           produces registered sync/colour outputs plus line/frame markers.
// Latency : registered outputs appear 1 clk after the strobe that samples pix_*.
// Backpr. : none; the raster free-runs while en=1, and en=0 parks it at (0,0) blanked.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   en                    run enable; low clears counters and blanks outputs
//   pix_r/g/b   [CW]      colour for the current (pix_x, pix_y), sampled when pix_req=1
//   pix_x [HW], pix_y [VW] current horizontal / vertical counters
//   pix_req               one-clk strobe: colour inputs are sampled this cycle
//   vga_hsync, vga_vsync  registered sync outputs (polarity from H_POL / V_POL)
//   vga_r/g/b   [CW]      registered colour outputs, zero outside the visible area
//   line_start            one-clk pulse with the output pixel at hcount 0
//   frame_start           one-clk pulse with the output pixel at (0,0)
module vga_timing_gen #(
    parameter int CLK_DIV   = 6,
    parameter int H_VISIBLE = 800,
    parameter int H_FRONT   = 40,
    parameter int H_SYNC    = 128,
    parameter int H_BACK    = 88,
    parameter int V_VISIBLE = 600,
    parameter int V_FRONT   = 1,
    parameter int V_SYNC    = 4,
    parameter int V_BACK    = 23,
    parameter int H_POL     = 1,
    parameter int V_POL     = 1,
    parameter int CW        = 4,
    parameter int HW        = 11,
    parameter int VW        = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic [CW-1:0] pix_r,
    input  logic [CW-1:0] pix_g,
    input  logic [CW-1:0] pix_b,
    output logic [HW-1:0] pix_x,
    output logic [VW-1:0] pix_y,
    output logic          pix_req,
    output logic          vga_hsync,
    output logic          vga_vsync,
    output logic [CW-1:0] vga_r,
    output logic [CW-1:0] vga_g,
    output logic [CW-1:0] vga_b,
    output logic          line_start,
    output logic          frame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    // A 1-bit tick register is kept for CLK_DIV=1; it simply stays at 0.
    localparam int TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(CLK_DIV - 1);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

    // Region bounds carry one extra bit so an end bound equal to TOTAL still fits.
    localparam logic [HW:0] H_VIS_END  = (HW+1)'(H_VISIBLE);
    localparam logic [HW:0] H_SYNC_BEG = (HW+1)'(H_VISIBLE + H_FRONT);
    localparam logic [HW:0] H_SYNC_END = (HW+1)'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [VW:0] V_VIS_END  = (VW+1)'(V_VISIBLE);
    localparam logic [VW:0] V_SYNC_BEG = (VW+1)'(V_VISIBLE + V_FRONT);
    localparam logic [VW:0] V_SYNC_END = (VW+1)'(V_VISIBLE + V_FRONT + V_SYNC);

    localparam logic HS_ACT = (H_POL != 0);
    localparam logic VS_ACT = (V_POL != 0);

    logic [TW-1:0] tick_q, tick_d;
    logic [HW-1:0] hcount_q, hcount_d;
    logic [VW-1:0] vcount_q, vcount_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic [CW-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
    logic          line_q, line_d;
    logic          frame_q, frame_d;

    logic strobe;
    logic h_wrap, v_wrap;
    logic h_vis, v_vis, visible;
    logic hs_on, vs_on;

    // All decode works on the pre-increment counters so the registered outputs
    // describe the pixel whose colour is being sampled in the same cycle.
    assign strobe  = en && (tick_q == TICK_LAST);
    assign h_wrap  = (hcount_q == H_LAST);
    assign v_wrap  = (vcount_q == V_LAST);
    assign h_vis   = ({1'b0, hcount_q} < H_VIS_END);
    assign v_vis   = ({1'b0, vcount_q} < V_VIS_END);
    assign visible = h_vis && v_vis;
    assign hs_on   = ({1'b0, hcount_q} >= H_SYNC_BEG) && ({1'b0, hcount_q} < H_SYNC_END);
    assign vs_on   = ({1'b0, vcount_q} >= V_SYNC_BEG) && ({1'b0, vcount_q} < V_SYNC_END);

    assign pix_req = strobe && visible;

    always_comb begin
        tick_d   = tick_q;
        hcount_d = hcount_q;
        vcount_d = vcount_q;
        hsync_d  = hsync_q;
        vsync_d  = vsync_q;
        r_d      = r_q;
        g_d      = g_q;
        b_d      = b_q;
        // Markers default low so they last exactly one clk.
        line_d   = 1'b0;
        frame_d  = 1'b0;

        if (!en) begin
            tick_d   = '0;
            hcount_d = '0;
            vcount_d = '0;
            hsync_d  = ~HS_ACT;
            vsync_d  = ~VS_ACT;
            r_d      = '0;
            g_d      = '0;
            b_d      = '0;
        end else begin
            tick_d = (tick_q == TICK_LAST) ? '0 : tick_q + 1'b1;
            if (strobe) begin
                hcount_d = h_wrap ? '0 : hcount_q + 1'b1;
                if (h_wrap) begin
                    vcount_d = v_wrap ? '0 : vcount_q + 1'b1;
                end
                hsync_d = hs_on ? HS_ACT : ~HS_ACT;
                vsync_d = vs_on ? VS_ACT : ~VS_ACT;
                r_d     = visible ? pix_r : '0;
                g_d     = visible ? pix_g : '0;
                b_d     = visible ? pix_b : '0;
                line_d  = (hcount_q == '0);
                frame_d = (hcount_q == '0) && (vcount_q == '0);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_q   <= '0;
            hcount_q <= '0;
            vcount_q <= '0;
            hsync_q  <= ~HS_ACT;
            vsync_q  <= ~VS_ACT;
            r_q      <= '0;
            g_q      <= '0;
            b_q      <= '0;
            line_q   <= 1'b0;
            frame_q  <= 1'b0;
        end else begin
            tick_q   <= tick_d;
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            r_q      <= r_d;
            g_q      <= g_d;
            b_q      <= b_d;
            line_q   <= line_d;
            frame_q  <= frame_d;
        end
    end

    assign pix_x       = hcount_q;
    assign pix_y       = vcount_q;
    assign vga_hsync   = hsync_q;
    assign vga_vsync   = vsync_q;
    assign vga_r       = r_q;
    assign vga_g       = g_q;
    assign vga_b       = b_q;
    assign line_start  = line_q;
    assign frame_start = frame_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances share clk/rst_n/en/pixel inputs.
//   a: CLK_DIV=2, positive syncs   b: CLK_DIV=2, negative syncs   c: CLK_DIV=1
// Expected values are keyed by sample index s (posedges since first reset release).
module tb_vga_timing_gen;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [3:0] pix_r, pix_g, pix_b;

    logic [3:0] a_px, b_px;
    logic [2:0] a_py, b_py;
    logic [3:0] c_px;
    logic [2:0] c_py;
    logic       a_req, b_req, c_req;
    logic       a_hs, a_vs, b_hs, b_vs, c_hs, c_vs;
    logic [3:0] a_r, a_g, a_b, b_r, b_g, b_b, c_r, c_g, c_b;
    logic       a_ls, a_fs, b_ls, b_fs, c_ls, c_fs;

    always #5 clk = ~clk;

    vga_timing_gen #(.CLK_DIV(2), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .H_POL(1), .V_POL(1),
        .CW(4), .HW(4), .VW(3)) u_a (
        .clk(clk), .rst_n(rst_n), .en(en), .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
        .pix_x(a_px), .pix_y(a_py), .pix_req(a_req), .vga_hsync(a_hs), .vga_vsync(a_vs),
        .vga_r(a_r), .vga_g(a_g), .vga_b(a_b), .line_start(a_ls), .frame_start(a_fs));

    vga_timing_gen #(.CLK_DIV(2), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .H_POL(0), .V_POL(0),
        .CW(4), .HW(4), .VW(3)) u_b (
        .clk(clk), .rst_n(rst_n), .en(en), .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
        .pix_x(b_px), .pix_y(b_py), .pix_req(b_req), .vga_hsync(b_hs), .vga_vsync(b_vs),
        .vga_r(b_r), .vga_g(b_g), .vga_b(b_b), .line_start(b_ls), .frame_start(b_fs));

    vga_timing_gen #(.CLK_DIV(1), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .H_POL(1), .V_POL(1),
        .CW(4), .HW(4), .VW(3)) u_c (
        .clk(clk), .rst_n(rst_n), .en(en), .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
        .pix_x(c_px), .pix_y(c_py), .pix_req(c_req), .vga_hsync(c_hs), .vga_vsync(c_vs),
        .vga_r(c_r), .vga_g(c_g), .vga_b(c_b), .line_start(c_ls), .frame_start(c_fs));

    // Observation selectors
    localparam int FS_A = 0,  LS_A = 1,  R_A = 2,  G_A = 3,  B_A = 4,  HS_A = 5,  VS_A = 6;
    localparam int PX_A = 7,  PY_A = 8,  REQ_A = 9, HS_B = 10, VS_B = 11;
    localparam int FS_C = 12, LS_C = 13, R_C = 14, REQ_C = 15, HS_C = 16;
    localparam int CNT_HS = 17, CNT_VS = 18, CNT_R = 19, CNT_LS = 20, CNT_FS = 21;

    typedef struct {
        int s;
        int sel;
        int val;
    } exp_t;

    exp_t q[$];
    int   s = 0;
    bit   started = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cnt_hs = 0, cnt_vs = 0, cnt_r = 0, cnt_ls = 0, cnt_fs = 0;

    function automatic string sel_name(input int sel);
        case (sel)
            FS_A:   return "a_frame_start";
            LS_A:   return "a_line_start";
            R_A:    return "a_vga_r";
            G_A:    return "a_vga_g";
            B_A:    return "a_vga_b";
            HS_A:   return "a_vga_hsync";
            VS_A:   return "a_vga_vsync";
            PX_A:   return "a_pix_x";
            PY_A:   return "a_pix_y";
            REQ_A:  return "a_pix_req";
            HS_B:   return "b_vga_hsync";
            VS_B:   return "b_vga_vsync";
            FS_C:   return "c_frame_start";
            LS_C:   return "c_line_start";
            R_C:    return "c_vga_r";
            REQ_C:  return "c_pix_req";
            HS_C:   return "c_vga_hsync";
            CNT_HS: return "a_hsync_clks_per_frame";
            CNT_VS: return "a_vsync_clks_per_frame";
            CNT_R:  return "a_red_clks_per_frame";
            CNT_LS: return "a_line_starts_per_frame";
            CNT_FS: return "a_frame_starts_per_256clk";
            default: return "unknown";
        endcase
    endfunction

    function automatic int get_obs(input int sel);
        case (sel)
            FS_A:   return int'(a_fs);
            LS_A:   return int'(a_ls);
            R_A:    return int'(a_r);
            G_A:    return int'(a_g);
            B_A:    return int'(a_b);
            HS_A:   return int'(a_hs);
            VS_A:   return int'(a_vs);
            PX_A:   return int'(a_px);
            PY_A:   return int'(a_py);
            REQ_A:  return int'(a_req);
            HS_B:   return int'(b_hs);
            VS_B:   return int'(b_vs);
            FS_C:   return int'(c_fs);
            LS_C:   return int'(c_ls);
            R_C:    return int'(c_r);
            REQ_C:  return int'(c_req);
            HS_C:   return int'(c_hs);
            CNT_HS: return cnt_hs;
            CNT_VS: return cnt_vs;
            CNT_R:  return cnt_r;
            CNT_LS: return cnt_ls;
            CNT_FS: return cnt_fs;
            default: return -1;
        endcase
    endfunction

    task automatic push(input int ss, input int sel, input int val);
        exp_t e;
        e.s = ss;
        e.sel = sel;
        e.val = val;
        q.push_back(e);
    endtask

    // Returns 1 clk-unit after the posedge at which s reaches target.
    task automatic wait_s(input int target);
        forever begin
            @(posedge clk);
            #1;
            if (s >= target) break;
        end
    endtask

    always @(posedge clk) begin
        if (started) s <= s + 1;
    end

    // Monitor: samples on the falling edge, accumulates first-frame statistics,
    // then retires every expectation due at this sample index.
    always @(negedge clk) begin
        if (started) begin
            if (s >= 2 && s <= 257) begin
                cnt_hs += int'(a_hs);
                cnt_vs += int'(a_vs);
                cnt_r  += (a_r == 4'hF) ? 1 : 0;
                cnt_ls += int'(a_ls);
                cnt_fs += int'(a_fs);
            end
            while (q.size() > 0 && q[0].s <= s) begin
                exp_t e;
                int   obs;
                e = q.pop_front();
                obs = get_obs(e.sel);
                checks++;
                if (e.s != s || obs != e.val) begin
                    errors++;
                    $display("FAIL %s at s=%0d (due s=%0d): got %0d expected %0d",
                             sel_name(e.sel), s, e.s, obs, e.val);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        en    = 1'b1;
        pix_r = 4'hF;
        pix_g = 4'h0;
        pix_b = 4'hA;

        // Phase 1: free run from reset release with en=1.
        push(0, FS_A, 0); push(0, LS_A, 0); push(0, R_A, 0); push(0, HS_A, 0);
        push(0, VS_A, 0); push(0, PX_A, 0); push(0, PY_A, 0); push(0, REQ_A, 0);
        push(0, HS_B, 1); push(0, VS_B, 1); push(0, REQ_C, 1);
        push(1, FS_A, 0); push(1, REQ_A, 1); push(1, FS_C, 1); push(1, LS_C, 1); push(1, R_C, 15);
        push(2, FS_A, 1); push(2, LS_A, 1); push(2, R_A, 15); push(2, G_A, 0); push(2, B_A, 10);
        push(2, PX_A, 1); push(2, PY_A, 0); push(2, REQ_A, 0); push(2, FS_C, 0);
        push(3, FS_A, 0); push(3, LS_A, 0); push(3, R_A, 15);
        push(7, REQ_C, 1);
        push(8, REQ_C, 0); push(8, R_C, 15);
        push(9, R_C, 0);
        push(10, HS_C, 0);
        push(11, HS_C, 1);
        push(13, HS_C, 1);
        push(14, HS_C, 0);
        push(15, REQ_A, 1);
        push(16, R_A, 15);
        push(17, REQ_A, 0); push(17, LS_C, 1);
        push(18, R_A, 0); push(18, B_A, 0);
        push(20, HS_A, 0); push(20, HS_B, 1);
        push(22, HS_A, 1); push(22, HS_B, 0);
        push(23, HS_A, 1);
        push(26, HS_A, 1);
        push(28, HS_A, 0); push(28, HS_B, 1);
        push(31, PX_A, 15); push(31, PY_A, 0);
        push(32, PX_A, 0); push(32, PY_A, 1);
        push(34, LS_A, 1); push(34, FS_A, 0); push(34, R_A, 15);
        push(128, FS_C, 0);
        push(129, FS_C, 1);
        push(130, R_A, 0); push(130, LS_A, 1);
        push(160, VS_A, 0); push(160, VS_B, 1);
        push(162, VS_A, 1); push(162, VS_B, 0);
        push(224, VS_A, 1);
        push(226, VS_A, 0);
        push(255, PX_A, 15); push(255, PY_A, 7);
        push(256, PX_A, 0); push(256, PY_A, 0);
        push(257, FS_A, 0);
        push(258, FS_A, 1); push(258, CNT_HS, 48); push(258, CNT_VS, 64); push(258, CNT_R, 64);
        push(258, CNT_LS, 8); push(258, CNT_FS, 1);

        repeat (3) @(posedge clk);
        #1;
        rst_n   = 1'b1;
        started = 1'b1;

        // Phase 2: drop en while a is at hcount=5, vcount=2, then restart.
        push(331, REQ_A, 0); push(331, R_A, 15);
        push(332, R_A, 0); push(332, HS_A, 0); push(332, LS_A, 0); push(332, FS_A, 0);
        push(332, PX_A, 0); push(332, PY_A, 0);
        push(336, R_A, 0);
        push(337, FS_A, 0); push(337, REQ_A, 1);
        push(338, FS_A, 1); push(338, LS_A, 1); push(338, R_A, 15);
        wait_s(331);
        en = 1'b0;
        wait_s(336);
        en = 1'b1;

        // Phase 3: async reset in the middle of an hsync pulse, then release.
        push(358, HS_A, 1); push(358, HS_B, 0); push(358, PX_A, 11);
        push(359, HS_A, 0); push(359, HS_B, 1); push(359, PX_A, 0); push(359, PY_A, 0);
        push(359, LS_A, 0);
        push(363, FS_A, 0); push(363, HS_A, 0); push(363, HS_B, 1);
        push(364, FS_A, 1); push(364, LS_A, 1); push(364, R_A, 15);
        wait_s(359);
        rst_n = 1'b0;
        wait_s(362);
        rst_n = 1'b1;

        wait_s(368);
        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL pending_expectations: got %0d left expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
